// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: checks line/frame periods against nominal timing, tracks lock
// and reports recovered x/y coordinates alongside the captured pixel.
module vga_sync_receiver #(
  parameter int H_ACTIVE        = 640,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int H_TOTAL         = 800,
  parameter int V_ACTIVE        = 480,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int V_TOTAL         = 525,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hs,
  input  logic       vs,
  input  logic [1:0] red_in,
  input  logic [1:0] green_in,
  input  logic [1:0] blue_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic [1:0] red_out,
  output logic [1:0] green_out,
  output logic [1:0] blue_out,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam logic       SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
  localparam logic [9:0] H_START   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_START   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END     = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX   = 10'd1023;
  localparam logic [7:0] LOCK_N    = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  logic       hs_reg, hs_d_reg, vs_reg, vs_d_reg;
  logic [5:0] rgb_reg;
  logic [9:0] h_cnt_reg, v_cnt_reg;
  logic       vs_pending_reg;
  state_t     state_reg;
  logic [7:0] good_frames_reg;
  logic [9:0] x_reg, y_reg;
  logic [5:0] rgb_out_reg;
  logic       pv_reg, fs_reg, locked_reg;
  logic [7:0] err_reg;

  logic       hs_edge, vs_edge, frame_evt, frame_good;
  logic       line_bad, timeout, lock_lost, vis;
  logic [9:0] h_cur, v_cur, h_inc, v_inc;

  // XOR with the idle level turns either sync polarity into active-high.
  assign hs_edge    = (hs_reg ^ SYNC_IDLE) & ~(hs_d_reg ^ SYNC_IDLE);
  assign vs_edge    = (vs_reg ^ SYNC_IDLE) & ~(vs_d_reg ^ SYNC_IDLE);
  assign h_inc      = (h_cnt_reg == CNT_MAX) ? CNT_MAX : h_cnt_reg + 10'd1;
  assign v_inc      = (v_cnt_reg == CNT_MAX) ? CNT_MAX : v_cnt_reg + 10'd1;
  assign h_cur      = hs_edge ? 10'd0 : h_inc;
  assign frame_evt  = hs_edge & (vs_pending_reg | vs_edge);
  assign v_cur      = frame_evt ? 10'd0 : (hs_edge ? v_inc : v_cnt_reg);
  assign frame_good = (v_cnt_reg == V_LAST);
  assign line_bad   = hs_edge & (h_cnt_reg != H_LAST);
  // Fires once, on the cycle the line counter first reaches saturation.
  assign timeout    = ~hs_edge & (h_cnt_reg == CNT_MAX - 10'd1);
  assign lock_lost  = line_bad | timeout | (frame_evt & ~frame_good);
  assign vis        = (h_cur >= H_START) && (h_cur < H_END) &&
                      (v_cur >= V_START) && (v_cur < V_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_reg          <= SYNC_IDLE;
      hs_d_reg        <= SYNC_IDLE;
      vs_reg          <= SYNC_IDLE;
      vs_d_reg        <= SYNC_IDLE;
      rgb_reg         <= '0;
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      vs_pending_reg  <= 1'b0;
      state_reg       <= SEARCH;
      good_frames_reg <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      rgb_out_reg     <= '0;
      pv_reg          <= 1'b0;
      fs_reg          <= 1'b0;
      locked_reg      <= 1'b0;
      err_reg         <= '0;
    end else if (en) begin
      hs_reg         <= hs;
      hs_d_reg       <= hs_reg;
      vs_reg         <= vs;
      vs_d_reg       <= vs_reg;
      rgb_reg        <= {red_in, green_in, blue_in};
      h_cnt_reg      <= h_cur;
      v_cnt_reg      <= v_cur;
      vs_pending_reg <= frame_evt ? 1'b0 : (vs_pending_reg | vs_edge);

      x_reg       <= vis ? h_cur - H_START : 10'd0;
      y_reg       <= vis ? v_cur - V_START : 10'd0;
      rgb_out_reg <= vis ? rgb_reg : 6'd0;
      pv_reg      <= vis && (state_reg == LOCKED) && !lock_lost;
      fs_reg      <= 1'b0;

      case (state_reg)
        SEARCH: begin
          if (frame_evt) begin
            state_reg       <= ACQUIRE;
            good_frames_reg <= '0;
          end
        end
        ACQUIRE: begin
          if (lock_lost) begin
            state_reg <= SEARCH;
          end else if (frame_evt) begin
            if (good_frames_reg + 8'd1 >= LOCK_N) begin
              state_reg  <= LOCKED;
              locked_reg <= 1'b1;
              fs_reg     <= 1'b1;
            end else begin
              good_frames_reg <= good_frames_reg + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (lock_lost) begin
            state_reg  <= SEARCH;
            locked_reg <= 1'b0;
            if (err_reg != 8'hFF) err_reg <= err_reg + 8'd1;
          end else if (frame_evt) begin
            fs_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= SEARCH;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign red_out     = rgb_out_reg[5:4];
  assign green_out   = rgb_out_reg[3:2];
  assign blue_out    = rgb_out_reg[1:0];
  assign pixel_valid = pv_reg & en;
  assign frame_start = fs_reg & en;
  assign locked      = locked_reg;
  assign err_count   = err_reg;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a compact video timing so that lock,
// loss, timeout and error saturation all fit in a short run.
module tb_vga_sync_receiver;

  localparam int TH_SYNC   = 2;
  localparam int TH_BP     = 2;
  localparam int TH_ACTIVE = 4;
  localparam int TH_TOTAL  = 10;
  localparam int TV_SYNC   = 1;
  localparam int TV_BP     = 1;
  localparam int TV_ACTIVE = 2;
  localparam int TV_TOTAL  = 5;

  logic       clk = 1'b0;
  logic       rst, en, hs, vs;
  logic [1:0] red_in, green_in, blue_in;
  logic [9:0] x, y;
  logic       pixel_valid, frame_start, locked;
  logic [1:0] red_out, green_out, blue_out;
  logic [7:0] err_count;

  int gx, gy, line_len;
  bit hs_off, freeze;
  int errors = 0;
  int checks = 0;

  vga_sync_receiver #(
    .H_ACTIVE(TH_ACTIVE), .H_SYNC(TH_SYNC), .H_BP(TH_BP), .H_TOTAL(TH_TOTAL),
    .V_ACTIVE(TV_ACTIVE), .V_SYNC(TV_SYNC), .V_BP(TV_BP), .V_TOTAL(TV_TOTAL),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hs(hs), .vs(vs),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .x(x), .y(y), .pixel_valid(pixel_valid),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .frame_start(frame_start), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rgb_of(input int px, input int py);
    logic [31:0] a, b;
    a = px;
    b = py;
    return {a[1:0], b[1:0], a[2:1] ^ b[1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    hs = (!hs_off && gx < TH_SYNC) ? 1'b0 : 1'b1;
    vs = (gy < TV_SYNC) ? 1'b0 : 1'b1;
    {red_in, green_in, blue_in} = rgb_of(gx, gy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!freeze) begin
      gx++;
      if (gx >= line_len) begin
        gx = 0;
        line_len = TH_TOTAL;
        gy++;
        if (gy >= TV_TOTAL) gy = 0;
      end
    end
    drive();
  endtask

  task automatic run_to(input int tx, input int ty);
    int n;
    n = 0;
    tick();
    while (!(gx == tx && gy == ty) && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_locked(input logic want, input int limit, input string tag);
    int n;
    n = 0;
    while (locked !== want && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(locked), 32'(want));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_pv"}, 32'(pixel_valid), 0);
    check({tag, "_rgb"}, 32'({red_out, green_out, blue_out}), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err"}, 32'(err_count), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; hs = 1'b1; vs = 1'b1;
    red_in = '0; green_in = '0; blue_in = '0;
    gx = 0; gy = 0; line_len = TH_TOTAL; hs_off = 1'b0; freeze = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    $display("step: reset state checked");

    // Acquisition: first frame start enters ACQUIRE, two good frames later LOCKED.
    rst = 1'b0;
    drive();
    tick(); tick();
    check("acq_fs1_locked", 32'(locked), 0);
    run_to(0, 0); tick(); tick();
    check("acq_fs2_locked", 32'(locked), 0);
    run_to(0, 0); tick();
    check("acq_fs3_pre_locked", 32'(locked), 0);
    check("acq_fs3_pre_fs", 32'(frame_start), 0);
    tick();
    check("lock_rise", 32'(locked), 1);
    check("lock_rise_fs", 32'(frame_start), 1);
    tick();
    check("fs_one_clk", 32'(frame_start), 0);
    run_to(0, 0); tick(); tick();
    check("fs_next_frame", 32'(frame_start), 1);
    check("lock_err0", 32'(err_count), 0);
    $display("step: lock acquisition checked");

    // Visible-region boundaries.
    run_to(4, 2); tick(); tick();
    check("pix_first_x", 32'(x), 0);
    check("pix_first_y", 32'(y), 0);
    check("pix_first_pv", 32'(pixel_valid), 1);
    check("pix_first_rgb", 32'({red_out, green_out, blue_out}), 32'(rgb_of(4, 2)));
    run_to(7, 3); tick(); tick();
    check("pix_last_x", 32'(x), 3);
    check("pix_last_y", 32'(y), 1);
    check("pix_last_pv", 32'(pixel_valid), 1);
    check("pix_last_rgb", 32'({red_out, green_out, blue_out}), 32'(rgb_of(7, 3)));
    tick();
    check("pix_after_pv", 32'(pixel_valid), 0);
    check("pix_after_x", 32'(x), 0);
    check("pix_after_rgb", 32'({red_out, green_out, blue_out}), 0);
    run_to(5, 4); tick(); tick();
    check("pix_vfp_pv", 32'(pixel_valid), 0);
    check("pix_vfp_y", 32'(y), 0);
    $display("step: pixel boundaries checked");

    // Clock enable held low with frozen stimulus.
    run_to(5, 2); tick(); tick();
    check("en_pre_x", 32'(x), 1);
    check("en_pre_pv", 32'(pixel_valid), 1);
    en = 1'b0; freeze = 1'b1;
    repeat (50) tick();
    check("en_hold_x", 32'(x), 1);
    check("en_hold_y", 32'(y), 0);
    check("en_hold_locked", 32'(locked), 1);
    check("en_hold_pv", 32'(pixel_valid), 0);
    en = 1'b1; freeze = 1'b0;
    tick();
    check("en_resume_x", 32'(x), 2);
    check("en_resume_pv", 32'(pixel_valid), 1);
    run_to(0, 0); tick(); tick();
    check("en_resume_locked", 32'(locked), 1);
    check("en_resume_fs", 32'(frame_start), 1);
    check("en_resume_err", 32'(err_count), 0);
    $display("step: clock enable checked");

    // One short line breaks lock at its closing hs edge.
    run_to(0, 2);
    line_len = TH_TOTAL - 1;
    run_to(0, 3); tick();
    check("short_pre_locked", 32'(locked), 1);
    tick();
    check("short_locked", 32'(locked), 0);
    check("short_err", 32'(err_count), 1);
    run_to(4, 3); tick(); tick();
    check("short_pv", 32'(pixel_valid), 0);
    check("short_y", 32'(y), 1);
    run_to(0, 0); run_to(0, 0); run_to(0, 0); tick(); tick();
    check("short_relock", 32'(locked), 1);
    check("short_relock_err", 32'(err_count), 1);
    $display("step: short line loss and relock checked");

    // Synchronous reset mid-frame while locked.
    run_to(7, 2);
    check("rst_pre_x", 32'(x), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_pulse");
    run_to(0, 0); run_to(0, 0); run_to(0, 0); tick(); tick();
    check("rst_relock", 32'(locked), 1);
    check("rst_relock_err", 32'(err_count), 0);
    $display("step: mid-frame reset checked");

    // hs held inactive: timeout exactly when the line counter reaches 1023.
    run_to(0, 1); tick();
    hs_off = 1'b1;
    drive();
    repeat (1023) tick();
    check("timeout_pre_locked", 32'(locked), 1);
    tick();
    check("timeout_locked", 32'(locked), 0);
    check("timeout_err", 32'(err_count), 1);
    hs_off = 1'b0;
    drive();
    wait_locked(1'b1, 1500, "timeout_relock");
    check("timeout_relock_err", 32'(err_count), 1);
    $display("step: timeout checked");

    // Repeated losses saturate the error counter at 255.
    for (int i = 0; i < 254; i++) begin
      run_to(0, 1);
      line_len = TH_TOTAL - 1;
      wait_locked(1'b0, 60, "sat_loss");
      wait_locked(1'b1, 400, "sat_relock");
    end
    check("sat_err_255", 32'(err_count), 255);
    run_to(0, 1);
    line_len = TH_TOTAL - 1;
    wait_locked(1'b0, 60, "sat_last_loss");
    check("sat_err_hold", 32'(err_count), 255);
    $display("step: error saturation checked");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
